vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and lock status from a VGA
// sync/colour stream.
// Inputs : clk, reset (async, active high), hsync_in/vsync_in (active low),
//          red_in/green_in/blue_in (2 bits each).
// Outputs: rgb_out, hor_count, ver_count, pixel_valid, frame_start (stage 2),
//          locked (lock FSM state), sync_error (one-cycle pulse).
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2,
    parameter int WD_LIMIT     = 816
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] red_in,
    input  logic [1:0] green_in,
    input  logic [1:0] blue_in,
    output logic [5:0] rgb_out,
    output logic [9:0] hor_count,
    output logic [9:0] ver_count,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_error
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(WD_LIMIT);
    localparam logic [WDW-1:0] WD_TRIP = WDW'(WD_LIMIT - 1);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    // Stage 1: registered pins plus delayed sync copies for edge detection.
    logic       hs1, vs1, hs1_d, vs1_d;
    logic [5:0] rgb1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            hs1_d <= 1'b0;
            vs1_d <= 1'b0;
            rgb1  <= '0;
        end else begin
            hs1   <= hsync_in;
            vs1   <= vsync_in;
            hs1_d <= hs1;
            vs1_d <= vs1;
            rgb1  <= {red_in, green_in, blue_in};
        end
    end

    logic       h_fall, v_fall, h_wrap;
    logic [9:0] hcount, vcount, h_inc, v_inc, h_next, v_next;
    logic       h_mis, v_mis, v_good, timeout, lose;
    logic [WDW-1:0] wd;

    assign h_fall = hs1_d & ~hs1;
    assign v_fall = vs1_d & ~vs1;

    // A sync load replaces the increment, so no wrap happens on that cycle.
    assign h_wrap = ~h_fall & (hcount == H_LAST);
    assign h_inc  = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
    assign v_inc  = h_wrap ? ((vcount == V_LAST) ? 10'd0 : vcount + 10'd1)
                           : vcount;
    assign h_next = h_fall ? H_SS : h_inc;
    assign v_next = v_fall ? V_SS : v_inc;

    assign h_mis   = h_fall & (h_inc != H_SS);
    assign v_mis   = v_fall & (v_inc != V_SS);
    assign v_good  = v_fall & (v_inc == V_SS);
    assign timeout = ~h_fall & (wd == WD_TRIP);
    assign lose    = timeout | h_mis | v_mis;

    // Watchdog saturates at the limit so it fires only once per outage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            wd     <= '0;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
            if (h_fall)
                wd <= '0;
            else if (wd != WD_MAX)
                wd <= wd + 1'b1;
        end
    end

    state_t         state, state_n;
    logic [GW-1:0]  good, good_n;
    logic           err_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        err_n   = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_n = VERIFY;
                    good_n  = '0;
                end
            end
            VERIFY: begin
                if (lose) begin
                    state_n = SEARCH;
                end else if (v_good) begin
                    good_n = good + 1'b1;
                    if (good + 1'b1 == GOOD_LOCK)
                        state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (lose) begin
                    state_n = SEARCH;
                    err_n   = 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    // Stage 2 uses the next count values: they index the pixel now in rgb1.
    logic valid_n;
    assign valid_n = locked & (h_next < H_ACT) & (v_next < V_ACT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hor_count   <= '0;
            ver_count   <= '0;
            pixel_valid <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            hor_count   <= h_next;
            ver_count   <= v_next;
            pixel_valid <= valid_n;
            rgb_out     <= valid_n ? rgb1 : 6'd0;
            frame_start <= valid_n & (h_next == 10'd0) & (v_next == 10'd0);
            sync_error  <= err_n;
        end
    end

endmodule
